usb_crc_tx: RTL and testbench

Transmit-side USB CRC generator for the USB serial interface. It accumulates CRC5 (token) or CRC16 (data) over payload bits as the transmit shifter emits them. On command it shifts out the ones-complemented remainder, MSB first, one bit per bit-time, and is muxed onto the NRZI/bit-stuff path. It is the counterpart of the receive-side CRC checker and uses the same polynomial conventions.

---
 rtl/usb_crc_pkg.sv | 10 +
 rtl/usb_crc_lfsr.sv | 12 +
 rtl/usb_crc_tx.sv | 86 ++++++++
 tb/tb_usb_crc_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg: shared USB CRC polynomials, presets, packet types and FSM states
package usb_crc_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, SEND} crc_state_t;
    localparam logic [4:0]  CRC5_POLY  = 5'b00101;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic        PKT_TOKEN  = 1'b0;
    localparam logic        PKT_DATA   = 1'b1;
endpackage

// File: rtl/usb_crc_lfsr.sv
// usb_crc_lfsr: one serial CRC step, MSB-out feedback, generic width and polynomial
module usb_crc_lfsr #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0
) (
    input  logic [WIDTH-1:0] crc,
    input  logic             d,
    output logic [WIDTH-1:0] next
);
    // shift left and fold in the polynomial when the incoming bit disagrees with the MSB
    always_comb next = {crc[WIDTH-2:0], 1'b0} ^ ((d ^ crc[WIDTH-1]) ? POLY : '0);
endmodule

// File: rtl/usb_crc_tx.sv
// usb_crc_tx: accumulates CRC5/CRC16 over transmitted payload and shifts out the complemented remainder
module usb_crc_tx
    import usb_crc_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic crc_clear,
    input  logic shift_enable,
    input  logic d_orig,
    input  logic crc_enable,
    input  logic packet_type,
    input  logic crc_send,
    output logic crc_bit,
    output logic crc_active,
    output logic crc_done
);
    crc_state_t  state, state_d;
    logic [4:0]  c5, c5_d, c5_n;
    logic [15:0] c16, c16_d, c16_n;
    logic [3:0]  cnt, cnt_d;
    logic        type_q, type_d, done_q, done_d;

    usb_crc_lfsr #(.WIDTH(5),  .POLY(CRC5_POLY))  u_crc5  (.crc(c5),  .d(d_orig), .next(c5_n));
    usb_crc_lfsr #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (.crc(c16), .d(d_orig), .next(c16_n));

    assign crc_active = (state == SEND);
    assign crc_bit    = crc_active & ~(type_q ? c16[cnt] : c5[cnt[2:0]]);
    assign crc_done   = done_q;

    // next-state: clear dominates, accumulation freezes once emission starts
    always_comb begin
        state_d = state;
        c5_d    = c5;
        c16_d   = c16;
        cnt_d   = cnt;
        type_d  = type_q;
        done_d  = 1'b0;
        if (crc_clear) begin
            state_d = IDLE;
            c5_d    = CRC5_INIT;
            c16_d   = CRC16_INIT;
            cnt_d   = '0;
        end else if (state == SEND) begin
            if (shift_enable) begin
                if (cnt == 4'd0) begin
                    state_d = IDLE;
                    c5_d    = CRC5_INIT;
                    c16_d   = CRC16_INIT;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
        end else begin
            if (crc_enable && shift_enable) begin
                state_d = ACCUM;
                c5_d    = c5_n;
                c16_d   = c16_n;
            end
            if (crc_send) begin
                state_d = SEND;
                type_d  = packet_type;
                cnt_d   = (packet_type == PKT_DATA) ? 4'd15 : 4'd4;
            end
        end
    end

    // state and remainder registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state  <= IDLE;
            c5     <= CRC5_INIT;
            c16    <= CRC16_INIT;
            cnt    <= '0;
            type_q <= PKT_TOKEN;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            c5     <= c5_d;
            c16    <= c16_d;
            cnt    <= cnt_d;
            type_q <= type_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_usb_crc_tx.sv
// tb_usb_crc_tx: randomized self-checking bench against a polynomial long-division CRC model
module tb_usb_crc_tx;
    logic clk = 1'b0, n_rst = 1'b0, crc_clear = 1'b0, shift_enable = 1'b0, d_orig = 1'b0;
    logic crc_enable = 1'b0, packet_type = 1'b0, crc_send = 1'b0;
    logic crc_bit, crc_active, crc_done;
    int   n_checks = 0, n_fail = 0;
    bit   payload[$];

    usb_crc_tx dut (
        .clk(clk), .n_rst(n_rst), .crc_clear(crc_clear), .shift_enable(shift_enable),
        .d_orig(d_orig), .crc_enable(crc_enable), .packet_type(packet_type),
        .crc_send(crc_send), .crc_bit(crc_bit), .crc_active(crc_active), .crc_done(crc_done)
    );

    always #5 clk = ~clk;

    // expected transmitted CRC: remainder of (ones*x^len + M*x^w) mod G, complemented
    function automatic logic [15:0] ref_crc(input int w);
        logic [15:0] g, mask, r;
        logic        m;
        bit          s[$];
        g    = (w == 5) ? 16'h0005 : 16'h8005;
        mask = (w == 5) ? 16'h001F : 16'hFFFF;
        r    = '0;
        s    = payload;
        for (int i = 0; i < w; i++) s.push_back(1'b0);
        for (int i = 0; i < w; i++) s[i] = ~s[i];
        foreach (s[i]) begin
            m = r[w-1];
            r = ((r << 1) | 16'(s[i])) & mask;
            if (m) r = r ^ g;
        end
        return ~r & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one payload bit preceded by idle cycles carrying junk on d_orig
    task automatic send_bit(input bit b, input int gap, input bit send, input bit ptype);
        repeat (gap) begin
            d_orig = 1'($urandom);
            tick();
        end
        d_orig = b; crc_enable = 1'b1; shift_enable = 1'b1; crc_send = send; packet_type = ptype;
        tick();
        shift_enable = 1'b0; crc_send = 1'b0;
    endtask

    task automatic do_send(input bit ptype);
        crc_send = 1'b1; packet_type = ptype;
        tick();
        crc_send = 1'b0;
    endtask

    task automatic load_random(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(1'($urandom));
    endtask

    // consume n CRC bits MSB first; bad counts protocol violations (active, stability, done)
    task automatic emit(input int n, input int max_gap, input int stall_at,
                        output logic [15:0] bits, output int bad);
        bits = '0; bad = 0;
        for (int i = n - 1; i >= 0; i--) begin
            logic b;
            int   gap;
            b   = crc_bit;
            gap = (i == stall_at) ? 1 : int'($urandom_range(max_gap));
            if (crc_active !== 1'b1 || crc_done !== 1'b0) bad++;
            repeat (gap) begin
                tick();
                if (crc_bit !== b || crc_active !== 1'b1) bad++;
            end
            bits[i] = b;
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
        end
        if (crc_done !== 1'b1 || crc_active !== 1'b0) bad++;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tick(); tick();
        n_checks++; if (crc_bit !== 1'b0) begin n_fail++; $display("FAIL reset_crc_bit got %b want 0", crc_bit); end
        n_checks++; if (crc_active !== 1'b0) begin n_fail++; $display("FAIL reset_crc_active got %b want 0", crc_active); end
        n_checks++; if (crc_done !== 1'b0) begin n_fail++; $display("FAIL reset_crc_done got %b want 0", crc_done); end
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_setup_token();
        logic [15:0] got; int bad;
        payload.delete();
        for (int i = 0; i < 11; i++) begin payload.push_back(1'b0); send_bit(1'b0, 0, 1'b0, 1'b0); end
        do_send(1'b0);
        n_checks++; if (crc_active !== 1'b1) begin n_fail++; $display("FAIL token_active_rise got %b want 1", crc_active); end
        emit(5, 0, -1, got, bad);
        n_checks++; if (got[4:0] !== 5'b01000) begin n_fail++; $display("FAIL token_setup_bits got %b want 01000", got[4:0]); end
        n_checks++; if (got[4:0] !== ref_crc(5)) begin n_fail++; $display("FAIL token_setup_model got %b want %b", got[4:0], ref_crc(5)); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL token_setup_protocol got %0d want 0", bad); end
        tick();
    endtask

    task automatic test_zero_len_data();
        logic [15:0] got; int bad;
        do_send(1'b1);
        emit(16, 2, -1, got, bad);
        n_checks++; if (got !== 16'h0000) begin n_fail++; $display("FAIL zlp_bits got %h want 0000", got); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL zlp_protocol got %0d want 0", bad); end
        tick();
        n_checks++; if (crc_done !== 1'b0) begin n_fail++; $display("FAIL zlp_done_pulse got %b want 0", crc_done); end
    endtask

    // last payload bit is strobed together with crc_send
    task automatic test_random_data();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] got; int bad;
            payload.delete();
            for (int j = 0; j < 8; j++) begin
                logic [7:0] by;
                by = 8'($urandom);
                for (int i = 0; i < 8; i++) begin
                    payload.push_back(by[i]);
                    send_bit(by[i], int'($urandom_range(7)), (j == 7 && i == 7), 1'b1);
                end
            end
            emit(16, 5, -1, got, bad);
            n_checks++; if (got !== ref_crc(16)) begin n_fail++; $display("FAIL data_crc16[%0d] got %h want %h", k, got, ref_crc(16)); end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL data_protocol[%0d] got %0d want 0", k, bad); end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [15:0] a, b; int bad_a, bad_b;
        load_random(24);
        foreach (payload[i]) send_bit(payload[i], 0, 1'b0, 1'b1);
        do_send(1'b1);
        emit(16, 0, -1, a, bad_a);
        foreach (payload[i]) send_bit(payload[i], 0, 1'b0, 1'b1);
        do_send(1'b1);
        emit(16, 0, 9, b, bad_b);
        n_checks++; if (b !== a) begin n_fail++; $display("FAIL stall_same_seq got %h want %h", b, a); end
        n_checks++; if (b !== ref_crc(16)) begin n_fail++; $display("FAIL stall_model got %h want %h", b, ref_crc(16)); end
        n_checks++; if (bad_a + bad_b !== 0) begin n_fail++; $display("FAIL stall_protocol got %0d want 0", bad_a + bad_b); end
        tick();
    endtask

    // inputs that should be ignored during emission are held active throughout
    task automatic test_send_ignored();
        logic [15:0] got; int bad;
        load_random(13);
        foreach (payload[i]) send_bit(payload[i], 1, i == 12, 1'b1);
        crc_send = 1'b1; packet_type = 1'b0; crc_enable = 1'b1; d_orig = 1'($urandom);
        emit(16, 1, -1, got, bad);
        crc_send = 1'b0; crc_enable = 1'b0;
        n_checks++; if (got !== ref_crc(16)) begin n_fail++; $display("FAIL ignored_inputs got %h want %h", got, ref_crc(16)); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ignored_protocol got %0d want 0", bad); end
        crc_clear = 1'b1; tick(); crc_clear = 1'b0;
    endtask

    task automatic test_clear();
        logic [15:0] got; int bad;
        load_random(16);
        foreach (payload[i]) send_bit(payload[i], 0, i == 15, 1'b1);
        for (int i = 0; i < 2; i++) begin shift_enable = 1'b1; tick(); shift_enable = 1'b0; end
        crc_clear = 1'b1; shift_enable = 1'b1; crc_send = 1'b1; packet_type = 1'b1;
        tick();
        crc_clear = 1'b0; shift_enable = 1'b0; crc_send = 1'b0;
        n_checks++; if (crc_active !== 1'b0) begin n_fail++; $display("FAIL clear_active got %b want 0", crc_active); end
        n_checks++; if (crc_done !== 1'b0) begin n_fail++; $display("FAIL clear_done got %b want 0", crc_done); end
        tick();
        n_checks++; if (crc_done !== 1'b0) begin n_fail++; $display("FAIL clear_done_late got %b want 0", crc_done); end
        load_random(11);
        foreach (payload[i]) send_bit(payload[i], int'($urandom_range(2)), 1'b0, 1'b0);
        do_send(1'b0);
        emit(5, 1, -1, got, bad);
        n_checks++; if (got[4:0] !== ref_crc(5)) begin n_fail++; $display("FAIL clear_token got %b want %b", got[4:0], ref_crc(5)); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clear_token_protocol got %0d want 0", bad); end
    endtask

    // next data accumulation starts on the very cycle crc_active falls
    task automatic test_back_to_back();
        logic [15:0] got; int bad;
        load_random(19);
        foreach (payload[i]) send_bit(payload[i], 0, i == 18, 1'b0);
        emit(5, 0, -1, got, bad);
        n_checks++; if (got[4:0] !== ref_crc(5)) begin n_fail++; $display("FAIL b2b_token got %b want %b", got[4:0], ref_crc(5)); end
        load_random(16);
        foreach (payload[i]) send_bit(payload[i], 0, i == 15, 1'b1);
        emit(16, 0, -1, got, bad);
        n_checks++; if (got !== ref_crc(16)) begin n_fail++; $display("FAIL b2b_data got %h want %h", got, ref_crc(16)); end
        tick();
    endtask

    task automatic test_midreset();
        logic [15:0] got; int bad;
        load_random(10);
        foreach (payload[i]) send_bit(payload[i], 0, 1'b0, 1'b1);
        n_rst = 1'b0; tick(); n_rst = 1'b1;
        n_checks++; if ({crc_bit, crc_active, crc_done} !== 3'b000) begin n_fail++; $display("FAIL midreset_outputs got %b want 000", {crc_bit, crc_active, crc_done}); end
        do_send(1'b1);
        emit(16, 1, -1, got, bad);
        n_checks++; if (got !== 16'h0000) begin n_fail++; $display("FAIL midreset_zlp got %h want 0000", got); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midreset_protocol got %0d want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_setup_token();
        test_zero_len_data();
        test_random_data();
        test_stall();
        test_send_ignored();
        test_clear();
        test_back_to_back();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
